// File: rtl/controlo_torneio.sv
// Round sequencer: runs the six pairwise matchups through a req/done handshake,
// latches each result onto its XJ flag, then samples Vitoria. Optional macro: TORNEIO_TIMEOUT_EN.
module controlo_torneio #(
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       Start,
    input  logic       PairDone,
    input  logic       PairResult,
    input  logic       Vitoria,
    output logic [2:0] PairSel,
    output logic       PairReq,
    output logic       XJ1eJ2,
    output logic       XJ1eJ3,
    output logic       XJ1eJ4,
    output logic       XJ2eJ3,
    output logic       XJ2eJ4,
    output logic       XJ3eJ4,
    output logic       Busy,
    output logic       Done,
    output logic       Win,
    output logic [3:0] Rounds,
    output logic [3:0] WinCount,
    output logic       Err
);

    typedef enum logic [1:0] {IDLE, REQ, EVAL, DONE} state_t;

    state_t     state;
    logic [5:0] flags;
    logic       advance;
    logic       store_val;
    logic       time_out;

    assign XJ1eJ2 = flags[0];
    assign XJ1eJ3 = flags[1];
    assign XJ1eJ4 = flags[2];
    assign XJ2eJ3 = flags[3];
    assign XJ2eJ4 = flags[4];
    assign XJ3eJ4 = flags[5];

`ifdef TORNEIO_TIMEOUT_EN
    logic [7:0] wait_cnt;
    logic       expire;

    // A PairDone in the expiry cycle takes precedence over the timeout.
    assign expire    = !PairDone && (wait_cnt == 8'(TIMEOUT_CYCLES - 1));
    assign advance   = PairDone || expire;
    assign store_val = PairDone && PairResult;
    assign time_out  = expire;

    always_ff @(posedge CLK) begin
        if (RST || state != REQ || advance) begin
            wait_cnt <= 8'd0;
        end else begin
            wait_cnt <= wait_cnt + 8'd1;
        end
    end
`else
    logic unused_cfg;

    assign unused_cfg = ^8'(TIMEOUT_CYCLES);
    assign advance    = PairDone;
    assign store_val  = PairResult;
    assign time_out   = 1'b0;
`endif

    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= IDLE;
            PairSel  <= 3'd0;
            flags    <= 6'd0;
            PairReq  <= 1'b0;
            Busy     <= 1'b0;
            Done     <= 1'b0;
            Win      <= 1'b0;
            Err      <= 1'b0;
            Rounds   <= 4'd0;
            WinCount <= 4'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (Start) begin
                        flags   <= 6'd0;
                        Err     <= 1'b0;
                        PairSel <= 3'd0;
                        PairReq <= 1'b1;
                        Busy    <= 1'b1;
                        state   <= REQ;
                    end
                end
                REQ: begin
                    if (advance) begin
                        for (int i = 0; i < 6; i++) begin
                            if (PairSel == 3'(i)) flags[i] <= store_val;
                        end
                        if (time_out) Err <= 1'b1;
                        if (PairSel == 3'd5) begin
                            PairReq <= 1'b0;
                            state   <= EVAL;
                        end else begin
                            PairSel <= PairSel + 3'd1;
                        end
                    end
                end
                EVAL: begin
                    Win <= Vitoria;
                    if (Rounds != 4'd15) Rounds <= Rounds + 4'd1;
                    if (Vitoria && WinCount != 4'd15) WinCount <= WinCount + 4'd1;
                    Done  <= 1'b1;
                    state <= DONE;
                end
                DONE: begin
                    Done  <= 1'b0;
                    Busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/controlo_torneio.md
# controlo_torneio

Round sequencer for the four-player victory evaluator. On each start it schedules the six pairwise matchups (J1eJ2, J1eJ3, J1eJ4, J2eJ3, J2eJ4, J3eJ4) one at a time through a request/done handshake with the match unit. It registers each pair result onto the matching XJ flag driving the combinational victory circuit, then samples `Vitoria` once all six flags are settled. It also keeps saturating round and win tallies.

## Interface

Parameters:
- `TIMEOUT_CYCLES`, default 15: consecutive `PairReq` cycles without `PairDone` before a pair is abandoned. Range 1–255. Used only when the timeout feature is compiled in.

Ports:
- `CLK`  in  1  system clock; all state changes on the rising edge.
- `RST`  in  1  reset. Synchronous, active-high.
- `Start`  in  1  begins a round. Sampled only in IDLE.
- `PairDone`  in  1  the match unit has finished the current pair. Sampled only in REQ.
- `PairResult`  in  1  pair outcome. Valid in the same cycle as `PairDone`.
- `Vitoria`  in  1  combinational output of the victory evaluator.
- `PairSel`  out  3  index of the current pair: 0=J1eJ2, 1=J1eJ3, 2=J1eJ4, 3=J2eJ3, 4=J2eJ4, 5=J3eJ4.
- `PairReq`  out  1  high while in REQ.
- `XJ1eJ2`, `XJ1eJ3`, `XJ1eJ4`, `XJ2eJ3`, `XJ2eJ4`, `XJ3eJ4`  out  1 each  registered pair flags feeding the evaluator.
- `Busy`  out  1  high in any state except IDLE.
- `Done`  out  1  one-cycle pulse when a round completes.
- `Win`  out  1  `Vitoria` as sampled for the last completed round.
- `Rounds`  out  4  completed rounds, saturating at 15.
- `WinCount`  out  4  rounds with `Win`=1, saturating at 15.
- `Err`  out  1  sticky: a pair timed out in the current or last round.

## Operation

States: IDLE, REQ, EVAL, DONE.

- **IDLE**
  - `Start`=1 → clear all six XJ flags and `Err`, set `PairSel`=0, go to REQ.
  - `Start`=0 → stay in IDLE.
- **REQ**
  - `PairReq`=1.
  - On a `PairDone` sample: write `PairResult` to the flag selected by `PairSel`.
  - If `PairSel`<5, increment `PairSel` and stay in REQ. If `PairSel`=5, go to EVAL; `PairSel` holds at 5.
- **EVAL**
  - All six flags are registered and stable, so `Vitoria` is valid.
  - `Win`←`Vitoria`.
  - `Rounds`+1, saturating at 15.
  - `WinCount`+1 if `Vitoria`=1, saturating at 15.
  - Go to DONE.
- **DONE**
  - `Done`=1 for this cycle only, then go to IDLE.
- XJ flags, `Win`, `PairSel` and `Err` hold after DONE until the next accepted `Start`. The tallies persist across rounds.
- `Start` outside IDLE is ignored, including `Start` held high during a round. `Start` still high in the cycle the block returns to IDLE starts a new round.
- `PairDone` outside REQ is ignored.
- The flag write is positional. Only the flag selected by `PairSel` changes; the other five hold.

## Timing

- Reset values:
  - state IDLE
  - `PairSel`=0
  - all XJ flags 0
  - `PairReq`, `Busy`, `Done`, `Win`, `Err` all 0
  - `Rounds`=0, `WinCount`=0
- A pair can complete in the first REQ cycle (zero-wait handshake).
- Minimum round, with `Start` sampled at edge n and `PairDone` tied high:
  - REQ from n to n+6; pairs captured at edges n+1 through n+6.
  - EVAL during cycle n+6 → n+7.
  - `Done` high during cycle n+7 → n+8.
  - IDLE after edge n+8.
  - Total: 8 cycles from `Start` acceptance to IDLE.
- Each extra wait cycle on a pair adds exactly one cycle to the round.
- `RST` has priority over every event. Asserted mid-round, it restores all reset values, including the tallies, at that edge. No `Done` is generated.
- Saturation: when `Rounds`=15, it stays 15 and `Win` still updates.

## Configuration

- `TORNEIO_TIMEOUT_EN` defined:
  - A per-pair wait counter runs in REQ and clears on each pair advance.
  - If `TIMEOUT_CYCLES` consecutive REQ cycles pass without `PairDone`, the current flag is written 0, `Err` is set, and the sequence advances exactly as if `PairDone` had arrived.
  - If `PairDone` arrives in the expiry cycle, `PairDone` wins: `PairResult` is stored and `Err` is not set.
- `TORNEIO_TIMEOUT_EN` undefined:
  - REQ waits indefinitely.
  - `Err` is constant 0.
  - No wait counter is built.

## Test plan

- Reset, then six `PairDone` pulses with `PairResult`=1 only on pair 2 (J1eJ4), evaluator driving `Vitoria`=1 → flags 001000 in pair order J1eJ2..J3eJ4 (only `XJ1eJ4`=1); `Done` 8 cycles after `Start` with zero-wait handshake; `Win`=1, `Rounds`=1, `WinCount`=1.
- Random 0–3 wait cycles per pair, all results 0, `Vitoria`=0 → `PairSel` steps 0..5 with no skips; `Win`=0; `Rounds`=1, `WinCount`=0; round length is 8 cycles plus total waits.
- `Start` pulsed at cycles 3 and 5 of a round, and `PairDone` pulsed in IDLE → no extra round, no flag change, `Rounds` increments once.
- `RST` asserted while `PairSel`=3 → next cycle IDLE, all flags 0, `Rounds`=0; no `Done` pulse.
- 17 back-to-back winning rounds → `Rounds`=15 and `WinCount`=15 from the 15th round onward, with no wrap.
- With `TORNEIO_TIMEOUT_EN` and `TIMEOUT_CYCLES`=4, `PairDone` withheld on pair 1 → advance after 4 REQ cycles, `XJ1eJ3`=0, `Err`=1 until the next `Start`. Repeat with `PairDone` arriving on the 4th cycle → result stored, `Err`=0.
